// File: rtl/regfile_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_scheduler_if
// Description : Request bus between writeback sources and the register-file
//               write scheduler. Requester i uses bit i of ReqValid/ReqReady
//               and slice i of the packed ReqAddr/ReqData vectors.
// Signals     : ReqValid [NUM_REQ]         write request per requester
//               ReqAddr  [NUM_REQ*ADDR_W]  destination register per requester
//               ReqData  [NUM_REQ*DATA_W]  write data per requester
//               ReqReady [NUM_REQ]         grant, accept on ReqValid & ReqReady
// Modports    : master - requester side, slave - scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        ReqReady;

    modport master (
        output ReqValid,
        output ReqAddr,
        output ReqData,
        input  ReqReady
    );

    modport slave (
        input  ReqValid,
        input  ReqAddr,
        input  ReqData,
        output ReqReady
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_scheduler
// Description : Shares the two write ports of a dual-write-port register file
//               between NUM_REQ requesters. Up to two requests are granted per
//               cycle in round-robin order; a request whose destination equals
//               that of the first grant is deferred, so the register file never
//               sees two same-cycle writes to one register.
// Ports       : Clk            clock, all state on posedge
//               Reset_n        asynchronous active-low reset
//               Enable         1 = scheduling allowed, 0 = no grants
//               reqBus         request bus (slave modport)
//               WriteRegister1/2, WriteData1/2, RegWrite1/2
//                              registered register-file write ports
//               Busy           valid requests exist that are not all granted
//               CollisionCount deferral counter (only with the macro below)
// Options     : WRITE_COLLISION_CNT_EN adds the 16-bit saturating
//               CollisionCount output.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Enable,
    regfile_write_scheduler_if.slave   reqBus,
    output logic [ADDR_W-1:0]          WriteRegister1,
    output logic [ADDR_W-1:0]          WriteRegister2,
    output logic [DATA_W-1:0]          WriteData1,
    output logic [DATA_W-1:0]          WriteData2,
    output logic                       RegWrite1,
    output logic                       RegWrite2,
    output logic                       Busy
`ifdef WRITE_COLLISION_CNT_EN
    ,
    output logic [15:0]                CollisionCount
`endif
);

    localparam int               PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   c_NUM_REQ  = (PTR_W + 1)'(NUM_REQ);

    // Unpacked views of the packed request vectors
    logic [ADDR_W-1:0] w_addrArr [NUM_REQ];
    logic [DATA_W-1:0] w_dataArr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addrArr[gi] = reqBus.ReqAddr[gi*ADDR_W +: ADDR_W];
            assign w_dataArr[gi] = reqBus.ReqData[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W:0]     w_scanSum;
    logic [PTR_W-1:0]   w_scanIdx;
    logic               w_foundA;
    logic               w_foundB;
    logic [PTR_W-1:0]   w_idxA;
    logic [PTR_W-1:0]   w_idxB;
    logic [ADDR_W-1:0]  w_addrA;
    logic [ADDR_W-1:0]  w_addrB;
    logic [DATA_W-1:0]  w_dataA;
    logic [DATA_W-1:0]  w_dataB;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_lastIdx;
    logic [PTR_W-1:0]   w_ptrNext;
`ifdef WRITE_COLLISION_CNT_EN
    logic               w_deferred;
    logic [15:0]        r_collisionCount;
`endif

    // Round-robin scan starting at r_ptr. The first valid requester takes
    // port 1; the first later one with a different destination takes port 2.
    // Same-destination requesters are skipped and simply stay ungranted.
    always_comb begin
        w_scanSum = '0;
        w_scanIdx = '0;
        w_foundA  = 1'b0;
        w_foundB  = 1'b0;
        w_idxA    = '0;
        w_idxB    = '0;
        w_addrA   = '0;
        w_addrB   = '0;
        w_dataA   = '0;
        w_dataB   = '0;
`ifdef WRITE_COLLISION_CNT_EN
        w_deferred = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modulo NUM_REQ without a divider: sum is always < 2*NUM_REQ
            w_scanSum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_scanSum >= c_NUM_REQ) begin
                w_scanSum = w_scanSum - c_NUM_REQ;
            end
            w_scanIdx = w_scanSum[PTR_W-1:0];
            if (Enable && reqBus.ReqValid[w_scanIdx]) begin
                if (!w_foundA) begin
                    w_foundA = 1'b1;
                    w_idxA   = w_scanIdx;
                    w_addrA  = w_addrArr[w_scanIdx];
                    w_dataA  = w_dataArr[w_scanIdx];
                end else if (w_addrArr[w_scanIdx] == w_addrA) begin
`ifdef WRITE_COLLISION_CNT_EN
                    w_deferred = 1'b1;
`endif
                end else if (!w_foundB) begin
                    w_foundB = 1'b1;
                    w_idxB   = w_scanIdx;
                    w_addrB  = w_addrArr[w_scanIdx];
                    w_dataB  = w_dataArr[w_scanIdx];
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = (w_foundA && (w_idxA == PTR_W'(i))) ||
                         (w_foundB && (w_idxB == PTR_W'(i)));
        end
    end

    // Grants are suppressed while reset is held so no write is accepted
    // that the output stage would then discard.
    assign reqBus.ReqReady = w_grant & {NUM_REQ{Reset_n}};

    assign Busy = (|reqBus.ReqValid) && (|(reqBus.ReqValid & ~reqBus.ReqReady));

    assign w_lastIdx = w_foundB ? w_idxB : w_idxA;
    assign w_ptrNext = (w_lastIdx == c_LAST_IDX) ? '0 : (w_lastIdx + 1'b1);

    // Output stage: an idle port drops its enable but keeps address/data
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr          <= '0;
            RegWrite1      <= 1'b0;
            RegWrite2      <= 1'b0;
            WriteRegister1 <= '0;
            WriteRegister2 <= '0;
            WriteData1     <= '0;
            WriteData2     <= '0;
        end else begin
            if (w_foundA) begin
                r_ptr          <= w_ptrNext;
                WriteRegister1 <= w_addrA;
                WriteData1     <= w_dataA;
            end
            RegWrite1 <= w_foundA;
            if (w_foundB) begin
                WriteRegister2 <= w_addrB;
                WriteData2     <= w_dataB;
            end
            RegWrite2 <= w_foundB;
        end
    end

`ifdef WRITE_COLLISION_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_collisionCount <= '0;
        end else if (w_deferred && (r_collisionCount != 16'hFFFF)) begin
            r_collisionCount <= r_collisionCount + 16'd1;
        end
    end

    assign CollisionCount = r_collisionCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_scheduler
// Description : Self-checking bench for regfile_write_scheduler (4 requesters).
//               Directed scenarios plus randomized traffic against a queue-based
//               reference model of the round-robin / conflict rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_scheduler;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk;
    logic          Reset_n;
    logic          Enable;
    logic [AW-1:0] WriteRegister1, WriteRegister2;
    logic [DW-1:0] WriteData1, WriteData2;
    logic          RegWrite1, RegWrite2;
    logic          Busy;
`ifdef WRITE_COLLISION_CNT_EN
    logic [15:0]   CollisionCount;
`endif

    regfile_write_scheduler_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_write_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Enable         (Enable),
        .reqBus         (bus),
        .WriteRegister1 (WriteRegister1),
        .WriteRegister2 (WriteRegister2),
        .WriteData1     (WriteData1),
        .WriteData2     (WriteData2),
        .RegWrite1      (RegWrite1),
        .RegWrite2      (RegWrite2),
        .Busy           (Busy)
`ifdef WRITE_COLLISION_CNT_EN
        ,
        .CollisionCount (CollisionCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_ptr;
    logic          m_rw1, m_rw2;
    logic [AW-1:0] m_wa1, m_wa2;
    logic [DW-1:0] m_wd1, m_wd2;
    int            m_coll;
    // Model view of the current cycle
    int            e_ga, e_gb;
    bit            e_coll;
    logic [N-1:0]  e_ready;
    logic          e_busy;

    function automatic logic [AW-1:0] addr_of(input int i);
        return bus.ReqAddr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return bus.ReqData[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.ReqValid[i]         = v;
        bus.ReqAddr[i*AW +: AW] = a;
        bus.ReqData[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        bus.ReqValid = '0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_rw1 = 0; m_rw2 = 0;
        m_wa1 = '0; m_wa2 = '0; m_wd1 = '0; m_wd2 = '0;
        m_coll = 0;
    endtask

    // Valid requesters listed in priority order from the pointer; the head
    // wins port 1, the first differing destination after it wins port 2.
    task automatic model_eval();
        int order[$];
        e_ga = -1; e_gb = -1; e_coll = 0; e_ready = '0;
        if (Reset_n && Enable) begin
            for (int k = 0; k < N; k++)
                if (bus.ReqValid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
            if (order.size() > 0) begin
                e_ga = order[0];
                for (int i = 1; i < order.size(); i++) begin
                    if (addr_of(order[i]) == addr_of(e_ga)) e_coll = 1;
                    else if (e_gb < 0) e_gb = order[i];
                end
            end
        end
        if (e_ga >= 0) e_ready[e_ga] = 1'b1;
        if (e_gb >= 0) e_ready[e_gb] = 1'b1;
        e_busy = (bus.ReqValid != 0) && ((bus.ReqValid & ~e_ready) != 0);
    endtask

    task automatic model_update();
        m_rw1 = (e_ga >= 0);
        if (e_ga >= 0) begin m_wa1 = addr_of(e_ga); m_wd1 = data_of(e_ga); end
        m_rw2 = (e_gb >= 0);
        if (e_gb >= 0) begin m_wa2 = addr_of(e_gb); m_wd2 = data_of(e_gb); end
        if (e_ga >= 0) m_ptr = (((e_gb >= 0) ? e_gb : e_ga) + 1) % N;
        if (e_coll && m_coll < 16'hFFFF) m_coll++;
    endtask

    // Advance one clock; leaves time at posedge + 1
    task automatic tick();
        model_eval();
        @(posedge Clk);
        if (Reset_n) model_update();
        #1;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        Enable  = 1'b1;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Enable  = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(8 + i), DW'(i));
        model_reset();
        repeat (3) @(posedge Clk);
        #2;
        n_checks++;
        if ({RegWrite1, RegWrite2} !== 2'b00) begin
            n_errors++; $display("FAIL reset_regwrite got %b want 00", {RegWrite1, RegWrite2});
        end
        n_checks++;
        if ({WriteRegister1, WriteRegister2, WriteData1, WriteData2} !== '0) begin
            n_errors++; $display("FAIL reset_wrport got %h/%h want 0", WriteRegister1, WriteData1);
        end
        n_checks++;
        if (bus.ReqReady !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ready got %b want 0000", bus.ReqReady);
        end
        Reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.ReqReady !== 4'b0011) begin
            n_errors++; $display("FAIL reset_first_grant got %b want 0011", bus.ReqReady);
        end
        clear_reqs();
    endtask

    task automatic test_distinct();
        apply_reset();
        set_req(0, 1'b1, 5'd3, 32'hA5A5_0003);
        set_req(1, 1'b1, 5'd4, 32'h5A5A_0004);
        #1;
        n_checks++;
        if ({bus.ReqReady, Busy} !== {4'b0011, 1'b0}) begin
            n_errors++; $display("FAIL distinct_ready got %b/%b want 0011/0", bus.ReqReady, Busy);
        end
        tick();
        clear_reqs();
        n_checks++;
        if ({RegWrite1, WriteRegister1, WriteData1} !== {1'b1, 5'd3, 32'hA5A5_0003}) begin
            n_errors++; $display("FAIL distinct_port1 got %b %0d %h want 1 3 a5a50003", RegWrite1, WriteRegister1, WriteData1);
        end
        n_checks++;
        if ({RegWrite2, WriteRegister2, WriteData2} !== {1'b1, 5'd4, 32'h5A5A_0004}) begin
            n_errors++; $display("FAIL distinct_port2 got %b %0d %h want 1 4 5a5a0004", RegWrite2, WriteRegister2, WriteData2);
        end
        // Pointer is now 2: requester 2 wins port 1, requester 0 port 2
        set_req(0, 1'b1, 5'd20, 32'h0000_0020);
        set_req(2, 1'b1, 5'd22, 32'h0000_0022);
        #1;
        n_checks++;
        if (bus.ReqReady !== 4'b0101) begin
            n_errors++; $display("FAIL distinct_ptr2 got %b want 0101", bus.ReqReady);
        end
        tick();
        clear_reqs();
        n_checks++;
        if ({WriteRegister1, WriteRegister2} !== {5'd22, 5'd20}) begin
            n_errors++; $display("FAIL distinct_ptr2_ports got %0d/%0d want 22/20", WriteRegister1, WriteRegister2);
        end
        // Single requester: only port 1 used
        set_req(3, 1'b1, 5'd9, 32'h0000_0999);
        tick();
        clear_reqs();
        n_checks++;
        if ({RegWrite1, WriteRegister1, RegWrite2} !== {1'b1, 5'd9, 1'b0}) begin
            n_errors++; $display("FAIL single_req got %b %0d %b want 1 9 0", RegWrite1, WriteRegister1, RegWrite2);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        set_req(0, 1'b1, 5'd0, 32'hC000_0000);
        set_req(1, 1'b1, 5'd0, 32'hC000_0001);
        set_req(2, 1'b1, 5'd1, 32'hC000_0002);
        #1;
        n_checks++;
        if ({bus.ReqReady, Busy} !== {4'b0101, 1'b1}) begin
            n_errors++; $display("FAIL coll_ready got %b/%b want 0101/1", bus.ReqReady, Busy);
        end
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if ({RegWrite1, WriteRegister1, WriteData1, RegWrite2, WriteRegister2, WriteData2} !==
            {1'b1, 5'd0, 32'hC000_0000, 1'b1, 5'd1, 32'hC000_0002}) begin
            n_errors++; $display("FAIL coll_ports got %0d %h / %0d %h want 0 c0000000 / 1 c0000002", WriteRegister1, WriteData1, WriteRegister2, WriteData2);
        end
        #1;
        n_checks++;
        if ({bus.ReqReady, Busy} !== {4'b0010, 1'b0}) begin
            n_errors++; $display("FAIL coll_deferred_ready got %b/%b want 0010/0", bus.ReqReady, Busy);
        end
        tick();
        clear_reqs();
        n_checks++;
        if ({RegWrite1, WriteRegister1, WriteData1, RegWrite2} !== {1'b1, 5'd0, 32'hC000_0001, 1'b0}) begin
            n_errors++; $display("FAIL coll_deferred_port got %b %0d %h %b want 1 0 c0000001 0", RegWrite1, WriteRegister1, WriteData1, RegWrite2);
        end
`ifdef WRITE_COLLISION_CNT_EN
        n_checks++;
        if (CollisionCount !== 16'd1) begin
            n_errors++; $display("FAIL coll_count got %0d want 1", CollisionCount);
        end
`endif
    endtask

    task automatic test_round_robin();
        int grants [N];
        apply_reset();
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(10 + i), $urandom);
        for (int c = 0; c < 4; c++) begin
            logic [N-1:0] want;
            want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            #1;
            n_checks++;
            if (bus.ReqReady !== want) begin
                n_errors++; $display("FAIL rr_ready_c%0d got %b want %b", c, bus.ReqReady, want);
            end
            for (int i = 0; i < N; i++) grants[i] += int'(bus.ReqReady[i]);
            tick();
            n_checks++;
            if ({WriteRegister1, WriteRegister2} !== {AW'(10 + 2 * (c % 2)), AW'(11 + 2 * (c % 2))}) begin
                n_errors++; $display("FAIL rr_ports_c%0d got %0d/%0d want %0d/%0d", c, WriteRegister1, WriteRegister2, 10 + 2 * (c % 2), 11 + 2 * (c % 2));
            end
            // Accepted requesters re-present with fresh data
            for (int i = 0; i < N; i++) if (e_ready[i]) set_req(i, 1'b1, AW'(10 + i), $urandom);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (grants[i] != 2) begin
                n_errors++; $display("FAIL rr_fair_req%0d got %0d want 2", i, grants[i]);
            end
        end
        clear_reqs();
    endtask

    task automatic test_enable_low();
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(16 + i), DW'(i));
        tick();
        Enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({bus.ReqReady, Busy} !== {4'b0000, 1'b1}) begin
                n_errors++; $display("FAIL en_low_ready_c%0d got %b/%b want 0000/1", c, bus.ReqReady, Busy);
            end
            tick();
            n_checks++;
            if ({RegWrite1, RegWrite2} !== 2'b00) begin
                n_errors++; $display("FAIL en_low_regwrite_c%0d got %b want 00", c, {RegWrite1, RegWrite2});
            end
        end
        Enable = 1'b1;
        #1;
        n_checks++;
        if (bus.ReqReady !== 4'b1100) begin
            n_errors++; $display("FAIL en_resume got %b want 1100", bus.ReqReady);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_req(0, 1'b1, 5'd7, 32'h0000_7777);
        tick();
        clear_reqs();
        n_checks++;
        if ({RegWrite1, WriteRegister1} !== {1'b1, 5'd7}) begin
            n_errors++; $display("FAIL arst_pre got %b %0d want 1 7", RegWrite1, WriteRegister1);
        end
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({RegWrite1, RegWrite2, WriteRegister1, WriteData1} !== '0) begin
            n_errors++; $display("FAIL arst_drop got %b %0d %h want 0 0 0", RegWrite1, WriteRegister1, WriteData1);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(24 + i), DW'(i));
        #1;
        n_checks++;
        if (bus.ReqReady !== 4'b0011) begin
            n_errors++; $display("FAIL arst_ptr got %b want 0011", bus.ReqReady);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            #1;
            model_eval();
            n_checks++;
            if ({bus.ReqReady, Busy} !== {e_ready, e_busy}) begin
                n_errors++; $display("FAIL rand_ready_c%0d got %b/%b want %b/%b", c, bus.ReqReady, Busy, e_ready, e_busy);
            end
            tick();
            n_checks++;
            if ({RegWrite1, WriteRegister1, WriteData1} !== {m_rw1, m_wa1, m_wd1}) begin
                n_errors++; $display("FAIL rand_port1_c%0d got %b %0d %h want %b %0d %h", c, RegWrite1, WriteRegister1, WriteData1, m_rw1, m_wa1, m_wd1);
            end
            n_checks++;
            if ({RegWrite2, WriteRegister2, WriteData2} !== {m_rw2, m_wa2, m_wd2}) begin
                n_errors++; $display("FAIL rand_port2_c%0d got %b %0d %h want %b %0d %h", c, RegWrite2, WriteRegister2, WriteData2, m_rw2, m_wa2, m_wd2);
            end
`ifdef WRITE_COLLISION_CNT_EN
            n_checks++;
            if (CollisionCount !== 16'(m_coll)) begin
                n_errors++; $display("FAIL rand_coll_c%0d got %0d want %0d", c, CollisionCount, m_coll);
            end
`endif
            // Requesters hold pending requests; after acceptance or when idle
            // they may issue a new one to a small address pool (forces clashes)
            for (int i = 0; i < N; i++) begin
                if (e_ready[i] || !bus.ReqValid[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(i, 1'b1, AW'($urandom_range(0, 3)), $urandom);
                    else
                        bus.ReqValid[i] = 1'b0;
                end
            end
            Enable = ($urandom_range(0, 9) != 0);
        end
        Enable = 1'b1;
        clear_reqs();
    endtask

    initial begin
        Reset_n      = 1'b0;
        Enable       = 1'b1;
        bus.ReqValid = '0;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        model_reset();
        test_reset();
        test_distinct();
        test_collision();
        test_round_robin();
        test_enable_low();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
